// File: rtl/regfile_seq_pkg.sv
// ---------------------------------------------------------------------------
// regfile_seq_pkg
// Shared definitions for the register-file command sequencer:
//   - default data / index widths
//   - command opcode encodings
//   - FSM state encoding
// ---------------------------------------------------------------------------
package regfile_seq_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 3;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_MOVI = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MOVI_WR = 3'd1,
        MOV_WR  = 3'd2,
        SWAP_RD = 3'd3,
        SWAP_W1 = 3'd4,
        SWAP_W2 = 3'd5,
        READ_RD = 3'd6,
        DONE    = 3'd7
    } state_t;

endpackage

// File: rtl/regfile_seq_ctrl_cmdreg.sv
// ---------------------------------------------------------------------------
// regfile_seq_ctrl_cmdreg
// Capture register for the accepted command and the SWAP temporary.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   load                    capture cmd_op/cmd_rd/cmd_rs/cmd_imm
//   cmd_op, cmd_rd,
//   cmd_rs, cmd_imm         command fields from the requester
//   tmp_load, tmp_data      capture tmp (first half of a SWAP)
//   op, rd, rs, imm, tmp    held values used by the controller decode
// ---------------------------------------------------------------------------
module regfile_seq_ctrl_cmdreg
    import regfile_seq_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs,
    input  logic [DW-1:0] cmd_imm,
    input  logic          tmp_load,
    input  logic [DW-1:0] tmp_data,
    output logic [1:0]    op,
    output logic [AW-1:0] rd,
    output logic [AW-1:0] rs,
    output logic [DW-1:0] imm,
    output logic [DW-1:0] tmp
);

    // Command fields are frozen at the handshake so the requester may change
    // its inputs freely while the sequence runs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op  <= '0;
            rd  <= '0;
            rs  <= '0;
            imm <= '0;
        end else if (load) begin
            op  <= cmd_op;
            rd  <= cmd_rd;
            rs  <= cmd_rs;
            imm <= cmd_imm;
        end
    end

    // tmp holds the original rd value across the two SWAP write cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmp <= '0;
        end else if (tmp_load) begin
            tmp <= tmp_data;
        end
    end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_seq_ctrl
// Serialises register-transfer commands (MOVI, MOV, SWAP, READ) onto the
// write and read ports of an 8x16 register file.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   cmd_valid, cmd_ready    command handshake (accepted only in IDLE)
//   cmd_op/rd/rs/imm        command fields
//   rf_writenum, rf_write,
//   rf_readnum, rf_data_in  drive the register file
//   rf_data_out             register file read data (combinational)
//   rsp_valid, rsp_data     READ result, valid for one cycle
//   done                    one-cycle pulse at the end of any command
//   busy                    high whenever not IDLE
// ---------------------------------------------------------------------------
module regfile_seq_ctrl
    import regfile_seq_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs,
    input  logic [DW-1:0] cmd_imm,
    output logic [AW-1:0] rf_writenum,
    output logic          rf_write,
    output logic [AW-1:0] rf_readnum,
    output logic [DW-1:0] rf_data_in,
    input  logic [DW-1:0] rf_data_out,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          done,
    output logic          busy
);

    state_t        state;
    logic          accept;
    logic [1:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [DW-1:0] imm;
    logic [DW-1:0] tmp;

    assign accept = cmd_valid && (state == IDLE);

    regfile_seq_ctrl_cmdreg #(
        .DW (DW),
        .AW (AW)
    ) u_cmdreg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .cmd_op   (cmd_op),
        .cmd_rd   (cmd_rd),
        .cmd_rs   (cmd_rs),
        .cmd_imm  (cmd_imm),
        .tmp_load (state == SWAP_RD),
        .tmp_data (rf_data_out),
        .op       (op),
        .rd       (rd),
        .rs       (rs),
        .imm      (imm),
        .tmp      (tmp)
    );

    // Sequencer state plus the READ result register. Each command walks a
    // fixed path ending in DONE, which always returns to IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_MOVI: state <= MOVI_WR;
                            OP_MOV:  state <= MOV_WR;
                            OP_SWAP: state <= SWAP_RD;
                            default: state <= READ_RD;
                        endcase
                    end
                end
                MOVI_WR: state <= DONE;
                MOV_WR:  state <= DONE;
                SWAP_RD: state <= SWAP_W1;
                SWAP_W1: state <= SWAP_W2;
                SWAP_W2: state <= DONE;
                READ_RD: begin
                    rsp_data <= rf_data_out;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode of the register-file controls from state and the captured
    // fields. MOV and SWAP_W1 forward rf_data_out straight to rf_data_in, so
    // these stay combinational rather than registered. SWAP_W1 reads rs while
    // writing rd: the new rd value is only visible next cycle, and rs still
    // holds its original value here. rf_write is masked by reset_n so a reset
    // arriving mid-command cannot commit the pending write.
    always_comb begin
        rf_write    = 1'b0;
        rf_writenum = '0;
        rf_readnum  = '0;
        rf_data_in  = '0;
        case (state)
            MOVI_WR: begin
                rf_write    = 1'b1;
                rf_writenum = rd;
                rf_data_in  = imm;
            end
            MOV_WR: begin
                rf_write    = 1'b1;
                rf_readnum  = rs;
                rf_writenum = rd;
                rf_data_in  = rf_data_out;
            end
            SWAP_RD: begin
                rf_readnum  = rd;
            end
            SWAP_W1: begin
                rf_write    = 1'b1;
                rf_readnum  = rs;
                rf_writenum = rd;
                rf_data_in  = rf_data_out;
            end
            SWAP_W2: begin
                rf_write    = 1'b1;
                rf_writenum = rs;
                rf_data_in  = tmp;
            end
            READ_RD: begin
                rf_readnum  = rs;
            end
            default: begin
                rf_write    = 1'b0;
            end
        endcase
        rf_write = rf_write && reset_n;
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign rsp_valid = (state == DONE) && (op == OP_READ);

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_seq_ctrl
// Self-checking bench: regfile_seq_ctrl driving a behavioural 8x16 register
// file. A table of commands is run with per-cycle tracing, followed by
// hand-written sequences for reset, held-valid-while-busy and reset abort.
// ---------------------------------------------------------------------------
module tb_regfile_seq_ctrl;
    import regfile_seq_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs;
    logic [15:0] cmd_imm;
    logic [2:0]  rf_writenum;
    logic        rf_write;
    logic [2:0]  rf_readnum;
    logic [15:0] rf_data_in;
    logic [15:0] rf_data_out;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int reset_writes = 0;

    regfile_seq_ctrl #(.DW(16), .AW(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rs      (cmd_rs),
        .cmd_imm     (cmd_imm),
        .rf_writenum (rf_writenum),
        .rf_write    (rf_write),
        .rf_readnum  (rf_readnum),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .done        (done),
        .busy        (busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: synchronous write, combinational read.
    // model_clear zeroes it once at start-up without touching it on later
    // resets, since a controller reset must not erase stored values.
    logic [15:0] regs [0:7];
    logic        model_clear;

    always @(posedge clk) begin
        if (model_clear) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else if (rf_write) begin
            regs[rf_writenum] <= rf_data_in;
        end
    end

    assign rf_data_out = regs[rf_readnum];

    // Any write strobe seen while reset_n is low is a fault.
    always @(posedge clk) begin
        if (!reset_n && rf_write) reset_writes++;
    end

    // Per-cycle trace of one command, index 1 = first cycle after accept.
    logic        tr_write [1:6];
    logic [2:0]  tr_wnum  [1:6];
    logic        tr_done  [1:6];
    logic        tr_ready [1:6];
    logic        tr_rspv  [1:6];
    logic [15:0] tr_rsp   [1:6];

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [15:0] imm;
        logic [15:0] exp_rsp;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Present one command, wait (bounded) for acceptance, then trace six cycles.
    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] rd,
                                 input logic [2:0] rs, input logic [15:0] imm);
        int wait_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_imm   = imm;
        wait_cnt  = 0;
        while (!cmd_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!cmd_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (k == 1) cmd_valid = 1'b0;
                tr_write[k] = rf_write;
                tr_wnum[k]  = rf_writenum;
                tr_done[k]  = done;
                tr_ready[k] = cmd_ready;
                tr_rspv[k]  = rsp_valid;
                tr_rsp[k]   = rsp_data;
            end
        end
    endtask

    initial begin
        int done_at;
        int done_cnt;
        int wr_cnt;
        int busy_cnt;
        int exp_done;
        int exp_wr;

        // ---------------- reset with cmd_valid asserted ----------------
        reset_n     = 1'b0;
        model_clear = 1'b1;
        cmd_valid   = 1'b1;
        cmd_op      = OP_MOVI;
        cmd_rd      = 3'd1;
        cmd_rs      = 3'd0;
        cmd_imm     = 16'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_write", {31'd0, rf_write}, 32'd0);
        checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        cmd_valid   = 1'b0;
        reset_n     = 1'b1;
        model_clear = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_no_accept_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_no_accept_r1", {16'd0, regs[1]}, 32'd0);

        // ---------------- table-driven command sequence ----------------
        vecs[0]  = '{OP_MOVI, 3'd3, 3'd0, 16'hABCD, 16'h0000};
        vecs[1]  = '{OP_READ, 3'd0, 3'd3, 16'h0000, 16'hABCD};
        vecs[2]  = '{OP_MOVI, 3'd1, 3'd0, 16'h0005, 16'h0000};
        vecs[3]  = '{OP_MOV,  3'd6, 3'd1, 16'h0000, 16'h0000};
        vecs[4]  = '{OP_READ, 3'd0, 3'd6, 16'h0000, 16'h0005};
        vecs[5]  = '{OP_READ, 3'd0, 3'd1, 16'h0000, 16'h0005};
        vecs[6]  = '{OP_MOVI, 3'd2, 3'd0, 16'h1111, 16'h0000};
        vecs[7]  = '{OP_MOVI, 3'd4, 3'd0, 16'h2222, 16'h0000};
        vecs[8]  = '{OP_SWAP, 3'd2, 3'd4, 16'h0000, 16'h0000};
        vecs[9]  = '{OP_READ, 3'd0, 3'd2, 16'h0000, 16'h2222};
        vecs[10] = '{OP_READ, 3'd0, 3'd4, 16'h0000, 16'h1111};
        vecs[11] = '{OP_MOVI, 3'd5, 3'd0, 16'h00FF, 16'h0000};
        vecs[12] = '{OP_SWAP, 3'd5, 3'd5, 16'h0000, 16'h0000};
        vecs[13] = '{OP_READ, 3'd0, 3'd5, 16'h0000, 16'h00FF};

        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].op, vecs[v].rd, vecs[v].rs, vecs[v].imm);
            exp_done = (vecs[v].op == OP_SWAP) ? 4 : 2;
            case (vecs[v].op)
                OP_SWAP: exp_wr = 2;
                OP_READ: exp_wr = 0;
                default: exp_wr = 1;
            endcase
            done_at  = 0;
            done_cnt = 0;
            wr_cnt   = 0;
            busy_cnt = 0;
            for (int k = 1; k <= 6; k++) begin
                if (tr_done[k]) begin
                    done_cnt++;
                    if (done_at == 0) done_at = k;
                end
                if (tr_write[k]) wr_cnt++;
            end
            for (int k = 1; k <= 6; k++) begin
                if (tr_ready[k]) break;
                busy_cnt++;
            end
            checkOutput($sformatf("v%0d_done_cycle", v), done_at, exp_done);
            checkOutput($sformatf("v%0d_done_pulses", v), done_cnt, 1);
            checkOutput($sformatf("v%0d_ready_low_cycles", v), busy_cnt, exp_done);
            checkOutput($sformatf("v%0d_write_count", v), wr_cnt, exp_wr);
            if (vecs[v].op == OP_MOVI || vecs[v].op == OP_MOV) begin
                checkOutput($sformatf("v%0d_write_at_t1", v), {31'd0, tr_write[1]}, 32'd1);
                checkOutput($sformatf("v%0d_writenum", v), {29'd0, tr_wnum[1]},
                            {29'd0, vecs[v].rd});
            end
            if (vecs[v].op == OP_MOVI) begin
                checkOutput($sformatf("v%0d_reg_value", v), {16'd0, regs[vecs[v].rd]},
                            {16'd0, vecs[v].imm});
            end
            if (vecs[v].op == OP_SWAP) begin
                checkOutput($sformatf("v%0d_w1_at_t2", v), {31'd0, tr_write[2]}, 32'd1);
                checkOutput($sformatf("v%0d_w1_num", v), {29'd0, tr_wnum[2]},
                            {29'd0, vecs[v].rd});
                checkOutput($sformatf("v%0d_w2_at_t3", v), {31'd0, tr_write[3]}, 32'd1);
                checkOutput($sformatf("v%0d_w2_num", v), {29'd0, tr_wnum[3]},
                            {29'd0, vecs[v].rs});
            end
            if (vecs[v].op == OP_READ) begin
                checkOutput($sformatf("v%0d_rsp_valid", v), {31'd0, tr_rspv[exp_done]}, 32'd1);
                checkOutput($sformatf("v%0d_rsp_data", v), {16'd0, tr_rsp[exp_done]},
                            {16'd0, vecs[v].exp_rsp});
            end else begin
                checkOutput($sformatf("v%0d_no_rsp_valid", v), {31'd0, tr_rspv[exp_done]}, 32'd0);
            end
        end

        // ---------------- cmd_valid held while busy ----------------
        // SWAP R5,R5 is accepted, then a MOVI R0 is held on the inputs; it
        // must wait out the four busy cycles before being taken.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_SWAP;
        cmd_rd    = 3'd5;
        cmd_rs    = 3'd5;
        cmd_imm   = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        cmd_op    = OP_MOVI;
        cmd_rd    = 3'd0;
        cmd_imm   = 16'h1234;
        busy_cnt  = 0;
        while (!cmd_ready && busy_cnt < 10) begin
            if (rf_write && rf_writenum == 3'd0) checkOutput("held_early_write", 32'd1, 32'd0);
            busy_cnt++;
            @(negedge clk);
        end
        checkOutput("held_busy_cycles", busy_cnt, 4);
        checkOutput("held_r0_untouched", {16'd0, regs[0]}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("held_r0_after", {16'd0, regs[0]}, 32'h1234);
        checkOutput("held_r5_same", {16'd0, regs[5]}, 32'h00FF);

        // ---------------- reset during SWAP_W1 ----------------
        applyStimulus(OP_MOVI, 3'd0, 3'd0, 16'hAAAA);
        applyStimulus(OP_MOVI, 3'd7, 3'd0, 16'h5555);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_SWAP;
        cmd_rd    = 3'd0;
        cmd_rs    = 3'd7;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_write_gated", {31'd0, rf_write}, 32'd0);
        @(negedge clk);
        checkOutput("abort_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_idle_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("abort_rsp_cleared", {16'd0, rsp_data}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort_r0_kept", {16'd0, regs[0]}, 32'hAAAA);
        checkOutput("abort_r7_kept", {16'd0, regs[7]}, 32'h5555);
        checkOutput("abort_still_idle", {31'd0, busy}, 32'd0);
        checkOutput("writes_during_reset", reset_writes, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
